// File: rtl/time_field_editor.sv
// -----------------------------------------------------------------------------
// time_field_editor
//
// Button-driven editor for an N-field two-digit value (e.g. hh:mm:ss).
// A working copy is loaded from i_value_in, the selected field is stepped
// up/down (press edge plus hold-to-auto-repeat) with wrap or saturate limits,
// and the result is published on commit. BCD digits and per-digit blink flags
// are produced for the LED driver.
//
// Ports:
//   i_clk, i_rst     clock, synchronous active-high reset
//   i_load           pulse: load working copy from i_value_in, enter EDIT
//   i_cancel         pulse: leave EDIT without publishing
//   i_commit         pulse: publish working copy, leave EDIT
//   i_value_in       binary value per field (8 bits each, field 0 at LSBs)
//   i_up_btn         step-up button, active-low
//   i_down_btn       step-down button, active-low
//   i_next_btn       field-select button, active-low
//   o_value_out      last committed value, binary per field
//   o_set_value      one-cycle strobe on commit
//   o_digits         BCD digits, tens at [8i+7:8i+4], ones at [8i+3:8i]
//   o_blink          per-digit blink flag, bit 2i = ones digit of field i
//   o_editing        high while in EDIT
// -----------------------------------------------------------------------------
module time_field_editor #(
    parameter int unsigned           N_FIELDS      = 3,
    parameter logic [8*N_FIELDS-1:0] FIELD_MAX     = {8'd23, 8'd59, 8'd59},
    parameter int unsigned           WRAP_MODE     = 1,
    parameter int unsigned           REPEAT_DELAY  = 25_000_000,
    parameter int unsigned           REPEAT_PERIOD = 5_000_000
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_load,
    input  logic                    i_cancel,
    input  logic                    i_commit,
    input  logic [8*N_FIELDS-1:0]   i_value_in,
    input  logic                    i_up_btn,
    input  logic                    i_down_btn,
    input  logic                    i_next_btn,
    output logic [8*N_FIELDS-1:0]   o_value_out,
    output logic                    o_set_value,
    output logic [8*N_FIELDS-1:0]   o_digits,
    output logic [2*N_FIELDS-1:0]   o_blink,
    output logic                    o_editing
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned CW   = $clog2(RMAX + 1);
    localparam int unsigned SW   = (N_FIELDS > 1) ? $clog2(N_FIELDS) : 1;

    typedef enum logic [0:0] {ST_IDLE, ST_EDIT} state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [SW-1:0]           r_sel;
    logic [8*N_FIELDS-1:0]   r_work;
    logic [8*N_FIELDS-1:0]   r_value_out;
    logic                    r_set_value;
    logic [8*N_FIELDS-1:0]   r_digits;
    logic [2*N_FIELDS-1:0]   r_blink;
    logic                    r_up_prev;
    logic                    r_dn_prev;
    logic                    r_nx_prev;
    logic [CW-1:0]           r_up_cnt;
    logic [CW-1:0]           r_dn_cnt;
    logic                    r_up_rep;
    logic                    r_dn_rep;

    logic                    w_in_edit;
    logic                    w_btn_active;
    logic                    w_up_low;
    logic                    w_dn_low;
    logic                    w_both_low;
    logic                    w_up_edge;
    logic                    w_dn_edge;
    logic                    w_nx_edge;
    logic [CW-1:0]           w_up_thr;
    logic [CW-1:0]           w_dn_thr;
    logic                    w_up_rpt;
    logic                    w_dn_rpt;
    logic                    w_up_step;
    logic                    w_dn_step;
    logic [7:0]              w_cur;
    logic [7:0]              w_max;
    logic [7:0]              w_inc;
    logic [7:0]              w_dec;
    logic [SW-1:0]           w_sel_inc;
    logic [8*N_FIELDS-1:0]   w_load_val;
    logic [8*N_FIELDS-1:0]   w_disp;
    logic [8*N_FIELDS-1:0]   w_bcd;
    logic [2*N_FIELDS-1:0]   w_blink_next;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (i_load)
            w_next_state = ST_EDIT;
        else if (r_state == ST_EDIT && (i_cancel || i_commit))
            w_next_state = ST_IDLE;
    end

    // ------------------------------------------------------ button decode
    assign w_in_edit    = (r_state == ST_EDIT);
    // Buttons only act in EDIT when no higher-priority control is present.
    assign w_btn_active = w_in_edit && !i_load && !i_cancel && !i_commit;
    assign w_up_low     = !i_up_btn;
    assign w_dn_low     = !i_down_btn;
    assign w_both_low   = w_up_low && w_dn_low;
    assign w_up_edge    = r_up_prev && w_up_low;
    assign w_dn_edge    = r_dn_prev && w_dn_low;
    assign w_nx_edge    = r_nx_prev && !i_next_btn;

    // A zero counter means "not armed": repeat only runs after a press edge.
    assign w_up_thr  = r_up_rep ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);
    assign w_dn_thr  = r_dn_rep ? CW'(REPEAT_PERIOD) : CW'(REPEAT_DELAY);
    assign w_up_rpt  = w_up_low && (r_up_cnt != '0) && (r_up_cnt == w_up_thr);
    assign w_dn_rpt  = w_dn_low && (r_dn_cnt != '0) && (r_dn_cnt == w_dn_thr);
    assign w_up_step = w_btn_active && !w_both_low && (w_up_edge || w_up_rpt);
    assign w_dn_step = w_btn_active && !w_both_low && (w_dn_edge || w_dn_rpt);

    // ------------------------------------------------------ field stepping
    assign w_cur = r_work[r_sel*8 +: 8];
    assign w_max = FIELD_MAX[r_sel*8 +: 8];
    assign w_inc = (w_cur >= w_max) ? ((WRAP_MODE != 0) ? 8'd0 : w_max) : (w_cur + 8'd1);
    assign w_dec = (w_cur == 8'd0)  ? ((WRAP_MODE != 0) ? w_max : 8'd0) : (w_cur - 8'd1);
    assign w_sel_inc = (r_sel == SW'(N_FIELDS - 1)) ? '0 : (r_sel + SW'(1));

    always_comb begin
        w_load_val = '0;
        for (int unsigned i = 0; i < N_FIELDS; i++) begin
            w_load_val[i*8 +: 8] = (i_value_in[i*8 +: 8] > FIELD_MAX[i*8 +: 8]) ?
                                   FIELD_MAX[i*8 +: 8] : i_value_in[i*8 +: 8];
        end
    end

    // ------------------------------------------------------ display path
    assign w_disp = w_in_edit ? r_work : i_value_in;

    always_comb begin
        w_bcd = '0;
        for (int unsigned i = 0; i < N_FIELDS; i++) begin
            w_bcd[i*8+4 +: 4] = 4'(w_disp[i*8 +: 8] / 8'd10);
            w_bcd[i*8   +: 4] = 4'(w_disp[i*8 +: 8] % 8'd10);
        end
    end

    // Blink uses the registered button samples so the suppression tracks
    // the same cycle the stepped value becomes visible.
    always_comb begin
        w_blink_next = '0;
        if (w_in_edit && r_up_prev && r_dn_prev)
            w_blink_next[2*r_sel +: 2] = 2'b11;
    end

    // ------------------------------------------------------ datapath regs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sel       <= '0;
            r_work      <= '0;
            r_value_out <= '0;
            r_set_value <= 1'b0;
            r_digits    <= '0;
            r_blink     <= '0;
            r_up_prev   <= 1'b1;
            r_dn_prev   <= 1'b1;
            r_nx_prev   <= 1'b1;
            r_up_cnt    <= '0;
            r_dn_cnt    <= '0;
            r_up_rep    <= 1'b0;
            r_dn_rep    <= 1'b0;
        end else begin
            r_up_prev   <= i_up_btn;
            r_dn_prev   <= i_down_btn;
            r_nx_prev   <= i_next_btn;
            r_set_value <= 1'b0;
            r_digits    <= w_bcd;
            r_blink     <= w_blink_next;

            if (i_load) begin
                r_work   <= w_load_val;
                r_sel    <= '0;
                r_up_cnt <= '0;
                r_dn_cnt <= '0;
                r_up_rep <= 1'b0;
                r_dn_rep <= 1'b0;
            end else if (w_btn_active) begin
                if (w_up_step)
                    r_work[r_sel*8 +: 8] <= w_inc;
                else if (w_dn_step)
                    r_work[r_sel*8 +: 8] <= w_dec;

                // Step above used the old selection; selection advances after.
                if (w_nx_edge)
                    r_sel <= w_sel_inc;

                if (w_both_low) begin
                    r_up_cnt <= '0;
                    r_up_rep <= 1'b0;
                end else if (w_up_edge) begin
                    r_up_cnt <= CW'(1);
                    r_up_rep <= 1'b0;
                end else if (w_up_low && r_up_cnt != '0) begin
                    if (w_up_rpt) begin
                        r_up_cnt <= CW'(1);
                        r_up_rep <= 1'b1;
                    end else begin
                        r_up_cnt <= r_up_cnt + CW'(1);
                    end
                end else begin
                    r_up_cnt <= '0;
                    r_up_rep <= 1'b0;
                end

                if (w_both_low) begin
                    r_dn_cnt <= '0;
                    r_dn_rep <= 1'b0;
                end else if (w_dn_edge) begin
                    r_dn_cnt <= CW'(1);
                    r_dn_rep <= 1'b0;
                end else if (w_dn_low && r_dn_cnt != '0) begin
                    if (w_dn_rpt) begin
                        r_dn_cnt <= CW'(1);
                        r_dn_rep <= 1'b1;
                    end else begin
                        r_dn_cnt <= r_dn_cnt + CW'(1);
                    end
                end else begin
                    r_dn_cnt <= '0;
                    r_dn_rep <= 1'b0;
                end
            end else begin
                if (w_in_edit && !i_cancel && i_commit) begin
                    r_value_out <= r_work;
                    r_set_value <= 1'b1;
                end
                r_up_cnt <= '0;
                r_dn_cnt <= '0;
                r_up_rep <= 1'b0;
                r_dn_rep <= 1'b0;
            end
        end
    end

    assign o_value_out = r_value_out;
    assign o_set_value = r_set_value;
    assign o_digits    = r_digits;
    assign o_blink     = r_blink;
    assign o_editing   = w_in_edit;

endmodule

// File: tb/tb_time_field_editor.sv
// -----------------------------------------------------------------------------
// tb_time_field_editor
//
// Scoreboard bench: stimulus pushes expected snapshots and expected commit
// values into queues; a negedge monitor pops and compares whenever a snapshot
// is requested or the DUT raises set_value. Instance A wraps, instance B
// saturates; both use a short auto-repeat (delay 8, period 4).
// -----------------------------------------------------------------------------
module tb_time_field_editor;

    typedef struct {
        int          dut;
        string       name;
        logic [23:0] dig;
        logic [5:0]  blk;
        logic        ed;
        logic [23:0] vo;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_load = 0, a_cancel = 0, a_commit = 0;
    logic [23:0] a_vin = '0;
    logic        a_up = 1, a_dn = 1, a_nx = 1;
    logic [23:0] a_vo, a_dig;
    logic        a_sv, a_ed;
    logic [5:0]  a_blk;

    logic        b_load = 0, b_cancel = 0, b_commit = 0;
    logic [23:0] b_vin = '0;
    logic        b_up = 1, b_dn = 1, b_nx = 1;
    logic [23:0] b_vo, b_dig;
    logic        b_sv, b_ed;
    logic [5:0]  b_blk;

    int          checks = 0;
    int          errors = 0;
    logic        snap_req = 1'b0;
    snap_t       sq[$];
    logic [23:0] cq[$];

    always #5 clk = ~clk;

    time_field_editor #(
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4)
    ) dut_a (
        .i_clk(clk), .i_rst(rst), .i_load(a_load), .i_cancel(a_cancel),
        .i_commit(a_commit), .i_value_in(a_vin), .i_up_btn(a_up),
        .i_down_btn(a_dn), .i_next_btn(a_nx), .o_value_out(a_vo),
        .o_set_value(a_sv), .o_digits(a_dig), .o_blink(a_blk), .o_editing(a_ed)
    );

    time_field_editor #(
        .WRAP_MODE    (0),
        .REPEAT_DELAY (8),
        .REPEAT_PERIOD(4)
    ) dut_b (
        .i_clk(clk), .i_rst(rst), .i_load(b_load), .i_cancel(b_cancel),
        .i_commit(b_commit), .i_value_in(b_vin), .i_up_btn(b_up),
        .i_down_btn(b_dn), .i_next_btn(b_nx), .o_value_out(b_vo),
        .o_set_value(b_sv), .o_digits(b_dig), .o_blink(b_blk), .o_editing(b_ed)
    );

    // ------------------------------------------------------------- monitor
    always @(negedge clk) begin
        logic [23:0] e;
        snap_t       s;
        logic [23:0] m_dig, m_vo;
        logic [5:0]  m_blk;
        logic        m_ed;
        if (a_sv) begin
            checks++;
            if (cq.size() == 0) begin
                errors++;
                $display("FAIL set_value_a: got unexpected pulse, value_out=%h, required no pulse", a_vo);
            end else begin
                e = cq.pop_front();
                if (a_vo !== e) begin
                    errors++;
                    $display("FAIL commit_value: got %h required %h", a_vo, e);
                end
            end
        end
        if (b_sv) begin
            checks++;
            errors++;
            $display("FAIL set_value_b: got unexpected pulse, required none");
        end
        if (snap_req) begin
            if (sq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snapshot: queue empty");
            end else begin
                s     = sq.pop_front();
                m_dig = (s.dut == 0) ? a_dig : b_dig;
                m_blk = (s.dut == 0) ? a_blk : b_blk;
                m_ed  = (s.dut == 0) ? a_ed  : b_ed;
                m_vo  = (s.dut == 0) ? a_vo  : b_vo;
                checks += 4;
                if (m_dig !== s.dig) begin
                    errors++;
                    $display("FAIL %s digits: got %h required %h", s.name, m_dig, s.dig);
                end
                if (m_blk !== s.blk) begin
                    errors++;
                    $display("FAIL %s blink: got %b required %b", s.name, m_blk, s.blk);
                end
                if (m_ed !== s.ed) begin
                    errors++;
                    $display("FAIL %s editing: got %b required %b", s.name, m_ed, s.ed);
                end
                if (m_vo !== s.vo) begin
                    errors++;
                    $display("FAIL %s value_out: got %h required %h", s.name, m_vo, s.vo);
                end
            end
        end
    end

    // ------------------------------------------------------------- helpers
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic snap(input int dut, input string nm, input logic [23:0] d,
                        input logic [5:0] b, input logic e, input logic [23:0] v);
        snap_t s;
        s.dut = dut; s.name = nm; s.dig = d; s.blk = b; s.ed = e; s.vo = v;
        sq.push_back(s);
        snap_req = 1'b1;
        @(negedge clk);
        #1 snap_req = 1'b0;
    endtask

    task automatic set_btn(input int dut, input int which, input logic lvl);
        if (dut == 0) begin
            case (which)
                0: a_up = lvl;
                1: a_dn = lvl;
                default: a_nx = lvl;
            endcase
        end else begin
            case (which)
                0: b_up = lvl;
                1: b_dn = lvl;
                default: b_nx = lvl;
            endcase
        end
    endtask

    // Hold a button low for n cycles, then release and let display settle.
    task automatic btn(input int dut, input int which, input int n);
        set_btn(dut, which, 1'b0);
        tick(n);
        set_btn(dut, which, 1'b1);
        tick(2);
    endtask

    task automatic load_a(input logic [23:0] v);
        a_vin = v; a_load = 1; tick(1); a_load = 0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        tick(2);
        rst = 1'b0;
        tick(1);
        snap(0, "reset", 24'h000000, 6'b000000, 1'b0, 24'h000000);

        // load + commit, no presses
        load_a({8'd23, 8'd59, 8'd58});
        tick(1);
        snap(0, "load1", 24'h235958, 6'b000011, 1'b1, 24'h000000);
        cq.push_back({8'd23, 8'd59, 8'd58});
        a_commit = 1; tick(1); a_commit = 0; tick(1);
        snap(0, "commit1", 24'h235958, 6'b000000, 1'b0, {8'd23, 8'd59, 8'd58});

        // up wraps 59->0, down wraps 0->59, cancel keeps value_out
        load_a({8'd12, 8'd0, 8'd59});
        btn(0, 0, 3);
        snap(0, "up_wrap", 24'h120000, 6'b000011, 1'b1, {8'd23, 8'd59, 8'd58});
        btn(0, 1, 3);
        snap(0, "dn_wrap", 24'h120059, 6'b000011, 1'b1, {8'd23, 8'd59, 8'd58});
        a_cancel = 1; tick(1); a_cancel = 0; tick(1);
        snap(0, "cancel", 24'h120059, 6'b000000, 1'b0, {8'd23, 8'd59, 8'd58});

        // saturating instance: up at max and down at 0 stay put
        b_vin = {8'd12, 8'd0, 8'd59};
        b_load = 1; tick(1); b_load = 0;
        btn(1, 0, 3);
        snap(1, "sat_up", 24'h120059, 6'b000011, 1'b1, 24'h000000);
        btn(1, 2, 2);
        btn(1, 1, 3);
        snap(1, "sat_dn", 24'h120059, 6'b001100, 1'b1, 24'h000000);

        // auto-repeat: steps at held cycles 0, 8, 12, 16 over 20 cycles
        load_a({8'd1, 8'd2, 8'd10});
        a_dn = 0;
        tick(5);
        snap(0, "hold_mid", 24'h010209, 6'b000000, 1'b1, {8'd23, 8'd59, 8'd58});
        tick(15);
        a_dn = 1;
        tick(2);
        snap(0, "hold_end", 24'h010206, 6'b000011, 1'b1, {8'd23, 8'd59, 8'd58});

        // select field 2, wrap hours 23->0, then selection wraps to 0
        load_a({8'd23, 8'd0, 8'd0});
        btn(0, 2, 2);
        btn(0, 2, 2);
        btn(0, 0, 2);
        snap(0, "hr_wrap", 24'h000000, 6'b110000, 1'b1, {8'd23, 8'd59, 8'd58});
        btn(0, 2, 2);
        snap(0, "sel_wrap", 24'h000000, 6'b000011, 1'b1, {8'd23, 8'd59, 8'd58});

        // commit with cancel: cancel wins, no publish
        a_commit = 1; a_cancel = 1; tick(1); a_commit = 0; a_cancel = 0; tick(1);
        snap(0, "cmt_cancel", 24'h230000, 6'b000000, 1'b0, {8'd23, 8'd59, 8'd58});

        // clamp on load, then publish clamped value
        load_a({8'd99, 8'd99, 8'd99});
        tick(1);
        snap(0, "clamp", 24'h235959, 6'b000011, 1'b1, {8'd23, 8'd59, 8'd58});
        cq.push_back({8'd23, 8'd59, 8'd59});
        a_commit = 1; tick(1); a_commit = 0; tick(1);
        snap(0, "clamp_cmt", 24'h999999, 6'b000000, 1'b0, {8'd23, 8'd59, 8'd59});

        // reset during edit discards everything without a publish
        load_a({8'd1, 8'd2, 8'd3});
        a_up = 0; tick(2);
        rst = 1; a_up = 1; a_vin = '0; tick(1);
        rst = 0; tick(2);
        snap(0, "rst_mid", 24'h000000, 6'b000000, 1'b0, 24'h000000);

        tick(3);
        checks++;
        if (cq.size() != 0) begin
            errors++;
            $display("FAIL commit_drain: got %0d pending commits required 0", cq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of stimulus required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

endmodule

// File: doc/time_field_editor.md
# time_field_editor

Parametrised multi-field value editor that takes over the button-driven editing of time, alarm and timer values from the display path. It holds a working copy of N two-digit fields (e.g. hh:mm:ss), steps the selected field up or down from active-low debounced buttons with hold-to-auto-repeat and wrap-or-saturate limits, and exports BCD digits plus per-digit blink flags to the LED driver. A commit strobe publishes the edited value to the clock/alarm/timer core.

## Interface
- N_FIELDS, 3: number of fields; field 0 is least significant, rightmost digit pair.
- FIELD_MAX, {8'd23,8'd59,8'd59}: packed 8-bit per-field maximum (binary, ≤ 99); field i is bits [8i+7:8i].
- WRAP_MODE, 1: 1 = wrap max↔0; 0 = saturate at 0 and max.
- REPEAT_DELAY, 25_000_000: cycles a button is held after its press edge before the first auto-repeat step (≥ 2).
- REPEAT_PERIOD, 5_000_000: cycles between subsequent auto-repeat steps (≥ 1).
- clk  in  1  system clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- load  in  1  pulse: copy value_in into the working registers and enter EDIT.
- cancel  in  1  pulse: leave EDIT without publishing.
- commit  in  1  pulse: publish the working value and leave EDIT.
- value_in  in  8*N_FIELDS  binary per-field value to edit.
- up_btn, down_btn, next_btn  in  1 each  debounced buttons, active-low (1 = released).
- value_out  out  8*N_FIELDS  last committed value, binary per field.
- set_value  out  1  one-cycle pulse on commit.
- digits  out  8*N_FIELDS  BCD: field i tens at [8i+7:8i+4], ones at [8i+3:8i].
- blink  out  2*N_FIELDS  per-digit blink flag, digit 2i = ones of field i.
- editing  out  1  high in EDIT.

## Operation
- FSM: IDLE, EDIT.
- IDLE: digits show value_in (registered); blink = 0; buttons ignored. load → EDIT.
- load, in either state: work ← value_in with each field clamped to its FIELD_MAX; sel ← 0; both repeat counters cleared.
- Press edge: the registered previous sample is 1 and the current input is 0. Each button has its own previous-sample register.
- EDIT, up press edge: work[sel] +1.
  - If work[sel] = max: becomes 0 when WRAP_MODE = 1, otherwise stays at max.
- EDIT, down press edge: work[sel] −1.
  - If work[sel] = 0: becomes max when WRAP_MODE = 1, otherwise stays at 0.
- EDIT, next_btn press edge: sel ← sel+1, wrapping from N_FIELDS−1 to 0.
- Auto-repeat, per button, while held continuously: steps at press edge (cycle 0), then at cycles REPEAT_DELAY, REPEAT_DELAY+REPEAT_PERIOD, and so on. Release clears the counter. next_btn does not repeat.
- up and down both low: no steps, both counters held at 0. Repeat resumes only on a new press edge.
- next and up/down press edge in the same cycle: the step applies to the old sel, then sel advances.
- blink: both digits of field sel = 1 in EDIT, all others 0. All blink bits are forced 0 while up or down is held, so the value stays readable.
- Priority in EDIT: load > cancel > commit > buttons. commit+cancel together gives cancel.
- commit: value_out ← work, set_value = 1 for one cycle, → IDLE.
- cancel: → IDLE; value_out unchanged.
- Binary→BCD: tens = v/10, ones = v%10, for v ≤ 99.

## Timing
- Reset values: FSM IDLE, sel 0, work 0, value_out 0, set_value 0, digits 0, blink 0, editing 0, button samples 1, repeat counters 0.
- Button edge seen at clock edge k: work updates at edge k; digits and blink update at edge k+1.
- load at edge k: editing = 1 and work loaded at k; digits and blink valid at k+1.
- commit at edge k: value_out valid and set_value high during cycle k→k+1. editing = 0 from k.
- Reset asserted mid-edit discards work and does not pulse set_value.

## Test plan
Bench overrides REPEAT_DELAY = 8 and REPEAT_PERIOD = 4.
- Reset with all buttons released: every output is 0; editing = 0.
- load with value_in = {23,59,58}, then commit with no presses: value_out = {23,59,58}; set_value high for exactly one cycle; digits = 0x235958.
- load {12,00,59}, press up once (pulse low for 3 cycles): field0 becomes 0 (WRAP_MODE = 1); blink = 6'b000011. Press down: field0 back to 59. With WRAP_MODE = 0, up leaves 59 and down from 0 leaves 0.
- Hold down low for 20 cycles from a press edge on field0 = 10: steps at cycles 0, 8, 12, 16, so field0 ends at 6. blink = 0 during the hold.
- Press next twice then up on {23,00,00}: field2 wraps 23→0; sel wraps back to 0 after a third next.
- Assert commit and cancel together with work ≠ value_out: value_out unchanged, no set_value pulse. load of {99,99,99} clamps to {23,59,59}.
